// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multicycle RV32I control FSM:
// state enum, opcodes, mux encodings and Moore output table.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    HALT
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic ADR_PC  = 1'b0;
  localparam logic ADR_RES = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       memReq;
    logic       memWrite;
    logic       regWrite;
    logic       adrSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic [1:0] aluOp;
  } ctrl_t;

  // Pure Moore outputs of a state; selects idle at 0.
  function automatic ctrl_t ctrlOf(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.memReq    = 1'b1;
        c.adrSrc    = ADR_PC;
        c.aluSrcA   = SRCA_PC;
        c.aluSrcB   = SRCB_FOUR;
        c.aluOp     = ALU_ADD;
        c.resultSrc = RES_ALURES;
      end
      DECODE: begin
        c.aluSrcA = SRCA_OLDPC;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALU_ADD;
      end
      MEMADR: begin
        c.aluSrcA = SRCA_RD1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALU_ADD;
      end
      MEMREAD: begin
        c.memReq    = 1'b1;
        c.adrSrc    = ADR_RES;
        c.resultSrc = RES_ALUOUT;
      end
      MEMWB: begin
        c.regWrite  = 1'b1;
        c.resultSrc = RES_RDATA;
      end
      MEMWRITE: begin
        c.memReq    = 1'b1;
        c.memWrite  = 1'b1;
        c.adrSrc    = ADR_RES;
        c.resultSrc = RES_ALUOUT;
      end
      EXECR: begin
        c.aluSrcA = SRCA_RD1;
        c.aluSrcB = SRCB_RD2;
        c.aluOp   = ALU_FUNCT;
      end
      EXECI: begin
        c.aluSrcA = SRCA_RD1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALU_FUNCT;
      end
      ALUWB: begin
        c.regWrite  = 1'b1;
        c.resultSrc = RES_ALUOUT;
      end
      BEQ: begin
        c.aluSrcA   = SRCA_RD1;
        c.aluSrcB   = SRCB_RD2;
        c.aluOp     = ALU_SUB;
        c.resultSrc = RES_ALUOUT;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Unified memory port handshake.
// master: mem_req, MemWrite out; mem_ready in.
interface multicycle_controller_if;
  logic mem_req;
  logic MemWrite;
  logic mem_ready;

  modport master (
    output mem_req,
    output MemWrite,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  MemWrite,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller_instr_class_decode.sv
// Opcode classifier: op -> instruction class flags
// plus immediate format (ImmSrc).
module instr_class_decode
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] op,
  output logic       isLw,
  output logic       isSw,
  output logic       isR,
  output logic       isI,
  output logic       isBeq,
  output logic       illegal,
  output logic [1:0] immSrc
);

  always_comb begin
    isLw    = 1'b0;
    isSw    = 1'b0;
    isR     = 1'b0;
    isI     = 1'b0;
    isBeq   = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OP_LW):  isLw  = 1'b1;
      (op == OP_SW):  isSw  = 1'b1;
      (op == OP_R):   isR   = 1'b1;
      (op == OP_I):   isI   = 1'b1;
      (op == OP_BEQ): isBeq = 1'b1;
      default:        illegal = 1'b1;
    endcase
  end

  always_comb begin
    immSrc = IMM_I;
    if (isSw)
      immSrc = IMM_S;
    else if (isBeq)
      immSrc = IMM_B;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: clk, rst (async low), Op, Zero,
// mem port (if), datapath enables/selects, illegal_op, dbg_state.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int ILLEGAL_HALT = 0,
  parameter int STATE_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         Op,
  input  logic               Zero,
  multicycle_controller_if.master mem,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               RegWrite,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         ALUOp,
  output logic               illegal_op,
  output logic [STATE_W-1:0] dbg_state
);

  localparam state_t ILL_NXT =
    (ILLEGAL_HALT != 0) ? HALT : FETCH;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;

  logic isLw;
  logic isSw;
  logic isR;
  logic isI;
  logic isBeq;
  logic illegal;
  logic fetchHit;

  instr_class_decode u_dec (
    .op      (Op),
    .isLw    (isLw),
    .isSw    (isSw),
    .isR     (isR),
    .isI     (isI),
    .isBeq   (isBeq),
    .illegal (illegal),
    .immSrc  (ImmSrc)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      FETCH:
        if (mem.mem_ready) nxt = DECODE;
      DECODE: begin
        unique case (1'b1)
          isLw, isSw: nxt = MEMADR;
          isR:        nxt = EXECR;
          isI:        nxt = EXECI;
          isBeq:      nxt = BEQ;
          default:    nxt = ILL_NXT;
        endcase
      end
      MEMADR:
        nxt = isSw ? MEMWRITE : MEMREAD;
      MEMREAD:
        if (mem.mem_ready) nxt = MEMWB;
      MEMWB:
        nxt = FETCH;
      MEMWRITE:
        if (mem.mem_ready) nxt = FETCH;
      EXECR, EXECI:
        nxt = ALUWB;
      ALUWB, BEQ:
        nxt = FETCH;
      HALT:
        nxt = HALT;
      default:
        nxt = FETCH;
    endcase
  end

  // Outputs registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      ctrl  <= ctrlOf(FETCH);
    end else begin
      state <= nxt;
      ctrl  <= ctrlOf(nxt);
    end
  end

  // FETCH values sit in ctrl during reset; gate the
  // request so nothing reaches memory until release.
  assign mem.mem_req  = ctrl.memReq & rst;
  assign mem.MemWrite = ctrl.memWrite;
  assign RegWrite     = ctrl.regWrite;
  assign AdrSrc       = ctrl.adrSrc;
  assign ALUSrcA      = ctrl.aluSrcA;
  assign ALUSrcB      = ctrl.aluSrcB;
  assign ResultSrc    = ctrl.resultSrc;
  assign ALUOp        = ctrl.aluOp;

  assign fetchHit =
    rst & (state == FETCH) & mem.mem_ready;
  assign IRWrite = fetchHit;
  assign PCWrite = fetchHit | ((state == BEQ) & Zero);

  assign illegal_op = (state == DECODE) & illegal;
  assign dbg_state  = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller:
// two instances (ILLEGAL_HALT 0 and 1) share stimulus.
`timescale 1ns/1ps
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  typedef struct {
    state_t s;
    logic   rdy;
    logic   z;
  } step_t;
  typedef logic [20:0] vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic       Zero;
  logic       memReady;
  int         total = 0;
  int         bad = 0;

  step_t plan[$];
  vec_t  o0[$];
  vec_t  o1[$];

  always #5 clk = ~clk;

  multicycle_controller_if m0 ();
  multicycle_controller_if m1 ();
  assign m0.mem_ready = memReady;
  assign m1.mem_ready = memReady;

  logic       mreq[2], mwr[2];
  logic       irW[2], pcW[2], regW[2];
  logic       adr[2], ill[2];
  logic [1:0] srcA[2], srcB[2], resS[2];
  logic [1:0] imm[2], aluOp[2];
  logic [3:0] dbg[2];

  assign mreq[0] = m0.mem_req;
  assign mreq[1] = m1.mem_req;
  assign mwr[0]  = m0.MemWrite;
  assign mwr[1]  = m1.MemWrite;

  multicycle_controller #(
    .ILLEGAL_HALT(0), .STATE_W(4)
  ) dut0 (
    .clk(clk), .rst(rst), .Op(Op), .Zero(Zero),
    .mem(m0), .IRWrite(irW[0]), .PCWrite(pcW[0]),
    .AdrSrc(adr[0]), .ALUSrcA(srcA[0]),
    .ALUSrcB(srcB[0]), .ResultSrc(resS[0]),
    .RegWrite(regW[0]), .ImmSrc(imm[0]),
    .ALUOp(aluOp[0]), .illegal_op(ill[0]),
    .dbg_state(dbg[0])
  );

  multicycle_controller #(
    .ILLEGAL_HALT(1), .STATE_W(4)
  ) dut1 (
    .clk(clk), .rst(rst), .Op(Op), .Zero(Zero),
    .mem(m1), .IRWrite(irW[1]), .PCWrite(pcW[1]),
    .AdrSrc(adr[1]), .ALUSrcA(srcA[1]),
    .ALUSrcB(srcB[1]), .ResultSrc(resS[1]),
    .RegWrite(regW[1]), .ImmSrc(imm[1]),
    .ALUOp(aluOp[1]), .illegal_op(ill[1]),
    .dbg_state(dbg[1])
  );

  // [20]req [19]wr [18]ir [17]pc [16]rw [15]adr
  // [14:13]A [12:11]B [10:9]res [8:7]op [6:5]imm
  // [4]illegal [3:0]state
  function automatic vec_t obs(int d);
    return {mreq[d], mwr[d], irW[d], pcW[d],
            regW[d], adr[d], srcA[d], srcB[d],
            resS[d], aluOp[d], imm[d], ill[d],
            dbg[d]};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference: expected outputs and care mask for a
  // cycle spent in state s, written from the state table.
  function automatic void want(
    input  state_t     s,
    input  logic       rdy,
    input  logic       z,
    input  logic [6:0] op,
    input  logic       run,
    output vec_t       v,
    output vec_t       c
  );
    logic mr, mw, ir, pw, rw, as, il;
    logic [1:0] sa, sb, rs, ao, im;
    logic cas, csa, csb, crs, cao;
    {mr, mw, ir, pw, rw, as, il} = '0;
    {sa, sb, rs, ao} = '0;
    {cas, csa, csb, crs, cao} = '0;
    if (op == 7'b0100011)      im = 2'b01;
    else if (op == 7'b1100011) im = 2'b10;
    else                       im = 2'b00;
    case (s)
      FETCH: begin
        mr = run; ir = rdy & run; pw = rdy & run;
        sb = 2'b10; rs = 2'b10;
        {cas, csa, csb, crs, cao} = '1;
      end
      DECODE: begin
        sa = 2'b01; sb = 2'b01;
        {csa, csb, cao} = '1;
        il = !(op inside {7'b0000011, 7'b0100011,
               7'b0110011, 7'b0010011, 7'b1100011});
      end
      MEMADR: begin
        sa = 2'b10; sb = 2'b01;
        {csa, csb, cao} = '1;
      end
      MEMREAD: begin
        mr = 1'b1; as = 1'b1;
        {cas, crs} = '1;
      end
      MEMWB: begin
        rw = 1'b1; rs = 2'b01; crs = 1'b1;
      end
      MEMWRITE: begin
        mr = 1'b1; mw = 1'b1; as = 1'b1;
        {cas, crs} = '1;
      end
      EXECR: begin
        sa = 2'b10; ao = 2'b10;
        {csa, csb, cao} = '1;
      end
      EXECI: begin
        sa = 2'b10; sb = 2'b01; ao = 2'b10;
        {csa, csb, cao} = '1;
      end
      ALUWB: begin
        rw = 1'b1; crs = 1'b1;
      end
      BEQ: begin
        sa = 2'b10; ao = 2'b01; pw = z;
        {csa, csb, cao, crs} = '1;
      end
      default: ;
    endcase
    v = {mr, mw, ir, pw, rw, as, sa, sb, rs, ao,
         im, il, 4'(s)};
    c = {5'h1f, cas, {2{csa}}, {2{csb}}, {2{crs}},
         {2{cao}}, 3'b111, 4'hf};
  endfunction

  function automatic step_t mk(
    state_t s, logic r, logic z);
    step_t t;
    t.s = s; t.rdy = r; t.z = z;
    return t;
  endfunction

  // Instruction-level model: the state walk of one
  // instruction with fw fetch waits and mw memory waits.
  task automatic build(
    input logic [6:0] op, input logic z,
    input int fw, input int mw);
    plan.delete();
    repeat (fw) plan.push_back(mk(FETCH, 1'b0, rb()));
    plan.push_back(mk(FETCH, 1'b1, rb()));
    plan.push_back(mk(DECODE, rb(), rb()));
    case (op)
      7'b0000011: begin
        plan.push_back(mk(MEMADR, rb(), rb()));
        repeat (mw)
          plan.push_back(mk(MEMREAD, 1'b0, rb()));
        plan.push_back(mk(MEMREAD, 1'b1, rb()));
        plan.push_back(mk(MEMWB, rb(), rb()));
      end
      7'b0100011: begin
        plan.push_back(mk(MEMADR, rb(), rb()));
        repeat (mw)
          plan.push_back(mk(MEMWRITE, 1'b0, rb()));
        plan.push_back(mk(MEMWRITE, 1'b1, rb()));
      end
      7'b0110011: begin
        plan.push_back(mk(EXECR, rb(), rb()));
        plan.push_back(mk(ALUWB, rb(), rb()));
      end
      7'b0010011: begin
        plan.push_back(mk(EXECI, rb(), rb()));
        plan.push_back(mk(ALUWB, rb(), rb()));
      end
      7'b1100011:
        plan.push_back(mk(BEQ, rb(), z));
      default: ;
    endcase
  endtask

  // Drive plan from a negedge; record both DUTs.
  task automatic run_plan();
    o0.delete();
    o1.delete();
    foreach (plan[k]) begin
      memReady = plan[k].rdy;
      Zero = plan[k].z;
      #1;
      o0.push_back(obs(0));
      o1.push_back(obs(1));
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    vec_t v, c;
    rst = 1'b0;
    memReady = 1'b1;
    Zero = 1'b1;
    Op = 7'b1100011;
    repeat (3) begin
      @(negedge clk);
      #1;
      want(FETCH, 1'b1, Zero, Op, 1'b0, v, c);
      for (int d = 0; d < 2; d++) begin
        total++;
        if ((obs(d) & c) !== (v & c)) begin
          bad++;
          $display("FAIL reset dut%0d got=%h want=%h",
                   d, obs(d) & c, v & c);
        end
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_lw();
    vec_t v, c;
    Op = 7'b0000011;
    build(Op, 1'b0, 0, 0);
    run_plan();
    foreach (plan[k]) begin
      want(plan[k].s, plan[k].rdy, plan[k].z,
           Op, 1'b1, v, c);
      total++;
      if ((o0[k] & c) !== (v & c)) begin
        bad++;
        $display("FAIL lw cyc%0d got=%h want=%h",
                 k, o0[k] & c, v & c);
      end
      total++;
      if ((o1[k] & c) !== (v & c)) begin
        bad++;
        $display("FAIL lw1 cyc%0d got=%h want=%h",
                 k, o1[k] & c, v & c);
      end
    end
  endtask

  task automatic test_sw_wait();
    vec_t v, c;
    int n;
    Op = 7'b0100011;
    build(Op, 1'b0, 1, 2);
    run_plan();
    n = 0;
    foreach (plan[k]) begin
      want(plan[k].s, plan[k].rdy, plan[k].z,
           Op, 1'b1, v, c);
      total++;
      if ((o0[k] & c) !== (v & c)) begin
        bad++;
        $display("FAIL sw cyc%0d got=%h want=%h",
                 k, o0[k] & c, v & c);
      end
      if (o0[k][19] && o0[k][15]) n++;
    end
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL sw_memwrite_cycles got=%0d want=3", n);
    end
  endtask

  task automatic test_beq();
    vec_t v, c;
    Op = 7'b1100011;
    for (int zi = 1; zi >= 0; zi--) begin
      build(Op, 1'(zi), 0, 0);
      run_plan();
      foreach (plan[k]) begin
        want(plan[k].s, plan[k].rdy, plan[k].z,
             Op, 1'b1, v, c);
        total++;
        if ((o0[k] & c) !== (v & c)) begin
          bad++;
          $display("FAIL beq z%0d cyc%0d got=%h want=%h",
                   zi, k, o0[k] & c, v & c);
        end
      end
    end
  endtask

  task automatic test_alu();
    vec_t v, c;
    logic [6:0] ops [2];
    ops[0] = 7'b0110011;
    ops[1] = 7'b0010011;
    for (int i = 0; i < 2; i++) begin
      Op = ops[i];
      build(Op, 1'b0, i, 0);
      run_plan();
      foreach (plan[k]) begin
        want(plan[k].s, plan[k].rdy, plan[k].z,
             Op, 1'b1, v, c);
        total++;
        if ((o0[k] & c) !== (v & c)) begin
          bad++;
          $display("FAIL alu op%h cyc%0d got=%h want=%h",
                   Op, k, o0[k] & c, v & c);
        end
      end
    end
  endtask

  task automatic test_illegal();
    vec_t v, c;
    Op = 7'b1111111;
    build(Op, 1'b0, 1, 0);
    run_plan();
    foreach (plan[k]) begin
      want(plan[k].s, plan[k].rdy, plan[k].z,
           Op, 1'b1, v, c);
      total++;
      if ((o0[k] & c) !== (v & c)) begin
        bad++;
        $display("FAIL ill0 cyc%0d got=%h want=%h",
                 k, o0[k] & c, v & c);
      end
      total++;
      if ((o1[k] & c) !== (v & c)) begin
        bad++;
        $display("FAIL ill1 cyc%0d got=%h want=%h",
                 k, o1[k] & c, v & c);
      end
    end
    for (int k = 0; k < 20; k++) begin
      memReady = rb();
      Zero = rb();
      #1;
      if (k == 0) begin
        total++;
        if (dbg[0] !== 4'(FETCH)) begin
          bad++;
          $display("FAIL ill0_refetch got=%0d want=%0d",
                   dbg[0], FETCH);
        end
      end
      want(HALT, memReady, Zero, Op, 1'b1, v, c);
      total++;
      if ((obs(1) & c) !== (v & c)) begin
        bad++;
        $display("FAIL halt cyc%0d got=%h want=%h",
                 k, obs(1) & c, v & c);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    memReady = 1'b0;
    Op = 7'b0000011;
    #1;
    want(FETCH, 1'b0, Zero, Op, 1'b0, v, c);
    total++;
    if ((obs(1) & c) !== (v & c)) begin
      bad++;
      $display("FAIL halt_rst got=%h want=%h",
               obs(1) & c, v & c);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    want(FETCH, 1'b0, Zero, Op, 1'b1, v, c);
    total++;
    if ((obs(1) & c) !== (v & c)) begin
      bad++;
      $display("FAIL halt_release got=%h want=%h",
               obs(1) & c, v & c);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    vec_t v, c;
    Op = 7'b0000011;
    build(Op, 1'b0, 0, 5);
    while (plan.size() > 4) void'(plan.pop_back());
    run_plan();
    foreach (plan[k]) begin
      want(plan[k].s, plan[k].rdy, plan[k].z,
           Op, 1'b1, v, c);
      total++;
      if ((o0[k] & c) !== (v & c)) begin
        bad++;
        $display("FAIL arst_pre cyc%0d got=%h want=%h",
                 k, o0[k] & c, v & c);
      end
    end
    memReady = 1'b0;
    #1;
    want(MEMREAD, 1'b0, Zero, Op, 1'b1, v, c);
    total++;
    if ((obs(0) & c) !== (v & c)) begin
      bad++;
      $display("FAIL arst_memread got=%h want=%h",
               obs(0) & c, v & c);
    end
    #2;
    rst = 1'b0;
    #1;
    want(FETCH, 1'b0, Zero, Op, 1'b0, v, c);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ((obs(d) & c) !== (v & c)) begin
        bad++;
        $display("FAIL arst_drop dut%0d got=%h want=%h",
                 d, obs(d) & c, v & c);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    Op = 7'b0110011;
    build(Op, 1'b0, 0, 0);
    run_plan();
    foreach (plan[k]) begin
      want(plan[k].s, plan[k].rdy, plan[k].z,
           Op, 1'b1, v, c);
      total++;
      if ((o0[k] & c) !== (v & c)) begin
        bad++;
        $display("FAIL arst_post cyc%0d got=%h want=%h",
                 k, o0[k] & c, v & c);
      end
    end
  endtask

  task automatic test_random();
    vec_t v, c;
    logic [6:0] ops [5];
    ops[0] = 7'b0000011;
    ops[1] = 7'b0100011;
    ops[2] = 7'b0110011;
    ops[3] = 7'b0010011;
    ops[4] = 7'b1100011;
    for (int n = 0; n < 30; n++) begin
      Op = ops[$urandom_range(0, 4)];
      build(Op, rb(), $urandom_range(0, 2),
            $urandom_range(0, 3));
      run_plan();
      foreach (plan[k]) begin
        want(plan[k].s, plan[k].rdy, plan[k].z,
             Op, 1'b1, v, c);
        total++;
        if ((o0[k] & c) !== (v & c)) begin
          bad++;
          $display("FAIL rnd%0d op%h cyc%0d got=%h want=%h",
                   n, Op, k, o0[k] & c, v & c);
        end
        total++;
        if ((o1[k] & c) !== (v & c)) begin
          bad++;
          $display("FAIL rnd1_%0d op%h cyc%0d got=%h want=%h",
                   n, Op, k, o1[k] & c, v & c);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    Op = 7'b0000011;
    Zero = 1'b0;
    memReady = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_alu();
    test_illegal();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for a multicycle RV32I datapath. Instruction memory and data memory are unified behind one memory port with a ready handshake.
- Sequences fetch, decode, execute, memory access and writeback for lw, sw, R-type, I-type ALU and beq.
- Drives the datapath enables and mux selects each cycle.
- Sits between the instruction register (Op) and the shared datapath; the ALU decoder consumes ALUOp.

Parameters:
- ILLEGAL_HALT, 0, 1 = unknown opcode enters sticky HALT until reset; 0 = skip the instruction and return to FETCH.
- STATE_W, 4, width of the state register and the dbg_state port.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Op  in  7  opcode field from the instruction register.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- MemWrite  out  1  store enable, qualified by mem_req.
- IRWrite  out  1  instruction register load.
- PCWrite  out  1  PC load.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1 register.
- ALUSrcB  out  2  ALU B select: 00 = RD2 register, 01 = ImmExt, 10 = constant 4.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = read data register, 10 = ALUResult.
- RegWrite  out  1  register file write enable.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B.
- ALUOp  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct fields.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unknown opcode.
- dbg_state  out  STATE_W  current state encoding.

Behaviour:
- Outputs are Moore-decoded from state. Exceptions: IRWrite and PCWrite also depend on mem_ready or Zero; ImmSrc depends only on Op.
- Reset: while rst is low, state = FETCH and mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal_op = 0. Selects take their FETCH values. A reset in the middle of any state aborts the access and returns to FETCH.
- Opcodes:
  - lw = 0000011
  - sw = 0100011
  - R-type = 0110011
  - I-type = 0010011
  - beq = 1100011
  - anything else is illegal.
- ImmSrc: S for sw, B for beq, I otherwise, in every state.
- FETCH:
  - Drives AdrSrc = 0, mem_req = 1, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Drives ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00, which computes the branch target into ALUOut.
  - Next state: lw or sw → MEMADR; R-type → EXECR; I-type → EXECI; beq → BEQ.
  - Illegal opcode → illegal_op = 1, then HALT if ILLEGAL_HALT = 1, else FETCH.
- MEMADR: drives ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: drives AdrSrc = 1, ResultSrc = 00, mem_req = 1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: drives ResultSrc = 01, RegWrite = 1. Goes to FETCH.
- MEMWRITE:
  - Drives AdrSrc = 1, ResultSrc = 00, mem_req = 1, MemWrite = 1.
  - MemWrite stays asserted for every wait cycle.
  - Goes to FETCH on mem_ready.
- EXECR: drives ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10. Goes to ALUWB.
- EXECI: drives ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Goes to ALUWB.
- ALUWB: drives ResultSrc = 00, RegWrite = 1. Goes to FETCH.
- BEQ:
  - Drives ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00.
  - PCWrite = Zero.
  - Goes to FETCH unconditionally.
- HALT: all enables 0; state held until reset.
- Latency with zero-wait memory:
  - lw 5 cycles.
  - sw, R-type, I-type 4 cycles.
  - beq 3 cycles.
  - Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Enables outside their listed states are 0. Selects outside their listed states are don't-care but must be driven to fixed values (no latches).
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

Decomposition:
- Shared package holds:
  - the state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, HALT);
  - the opcode constants;
  - the AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc and ALUOp encodings.
- One sub-module, instr_class_decode: combinational Op → {is_lw, is_sw, is_r, is_i, is_beq, illegal} and ImmSrc. The FSM and the output decode stay in multicycle_controller.

Test Plan:
- lw, mem_ready held at 1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite = 1 only in cycle 5 with ResultSrc = 01. IRWrite = 1 only in cycle 1.
- sw with mem_ready low for 2 cycles in MEMWRITE → MemWrite = 1 and AdrSrc = 1 for 3 consecutive cycles, then FETCH. RegWrite never asserted.
- beq with Zero = 1, then beq with Zero = 0 → PCWrite = 1 in cycle 3 for the first, 0 for the second. ALUOp = 01 in BEQ. Each takes 3 cycles.
- R-type (0110011) and I-type (0010011) → 4 cycles each. ALUSrcB = 00 versus 01 in the execute state. ALUOp = 10. RegWrite in cycle 4.
- Op = 1111111 with ILLEGAL_HALT = 0 → illegal_op pulses in DECODE, then FETCH. With ILLEGAL_HALT = 1 → HALT holds for 20 cycles with all enables 0, and releasing reset returns to FETCH.
- rst driven low asynchronously mid-MEMREAD → mem_req and RegWrite drop immediately. After release, dbg_state = FETCH and fetch restarts.
